mem_trace_reader: RTL and testbench

- Drains a memory-transaction trace buffer through its external MemSplit32 slave port.
- Walks entries 0..N-1 oldest-first and reads three words per entry: address, data, write flag.
- Assembles each entry into one record and streams records out on a valid/ready port to a debug sink (UART packer or host mailbox).
- Sits in sigma_tile next to the tracer. Runs only after tracing has been stopped (trace enable low), so it never races trace writes.

---
 rtl/mem_trace_reader_if.sv | 16 +
 rtl/mem_trace_reader.sv | 206 ++++++++++++++++++++
 tb/tb_mem_trace_reader.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_trace_reader_if.sv
// Split request/response 32-bit memory port; ack accepts a request, resp returns its read data.
// No internal state or latency of its own.
// Backpressure: the slave withholds ack; the master keeps req and addr stable until acked.
interface MemSplit32;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;

    modport Master (output req, we, addr, be, wdata, input ack, resp, rdata);
    modport Slave  (input req, we, addr, be, wdata, output ack, resp, rdata);
endinterface

// File: rtl/mem_trace_reader.sv
// Reads trace entries (address, data, write flag) over MemSplit32 and streams one record per entry.
// Latency: first req 2 cycles after start; 7 cycles per entry with ack=1 and 1-cycle resp.
// Backpressure: bus fetches wait for a free FIFO slot, so a stalled sink stalls reads and drops nothing.
module mem_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             full,
    output logic             empty,
    output logic             head_vld,
    input  logic             head_rdy,
    output logic [WIDTH-1:0] head_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_CNT);
    assign head_vld = !empty;
    assign head_dat = mem[rd_ptr];
    assign do_pop   = head_vld && head_rdy;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push  = push_vld && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module mem_trace_reader #(
    parameter int          CAPACITY   = 256,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic [$clog2(CAPACITY):0]     num_entries_i,
    output logic                          busy_o,
    output logic                          done_o,
    MemSplit32.Master                     trace_if,
    output logic                          rec_valid_o,
    input  logic                          rec_ready_i,
    output logic [$clog2(CAPACITY)-1:0]   rec_idx_o,
    output logic [31:0]                   rec_addr_o,
    output logic [31:0]                   rec_data_o,
    output logic                          rec_we_o
);
    localparam int IW = $clog2(CAPACITY);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] CAP_CNT = CW'(CAPACITY);

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [31:0]   addr;
        logic [31:0]   data;
        logic          we;
    } rec_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_d;
    logic [CW-1:0] cnt;
    logic [CW-1:0] idx;
    logic [1:0]    field;
    logic [31:0]   addr_q;
    logic [31:0]   data_q;
    logic          req;
    logic          push;
    logic          fifo_full;
    logic          fifo_empty;
    rec_t          push_rec;
    rec_t          head_rec;

    always_comb begin
        state_d = state;
        req     = 1'b0;
        push    = 1'b0;
        case (state)
            S_IDLE:  if (start_i) state_d = S_CHECK;
            S_CHECK: begin
                if (idx == cnt)      state_d = S_DRAIN;
                else if (!fifo_full) state_d = S_REQ;
            end
            S_REQ: begin
                req = 1'b1;
                if (trace_if.ack) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (trace_if.resp) begin
                    if (field == 2'd2) begin
                        push    = 1'b1;
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_DRAIN: if (fifo_empty) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            idx    <= '0;
            field  <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state <= state_d;
            if (state == S_IDLE && start_i) begin
                cnt   <= (num_entries_i > CAP_CNT) ? CAP_CNT : num_entries_i;
                idx   <= '0;
                field <= '0;
            end
            // resp outside WAIT has no outstanding request behind it and is dropped.
            if (state == S_WAIT && trace_if.resp) begin
                case (field)
                    2'd0:    addr_q <= trace_if.rdata;
                    2'd1:    data_q <= trace_if.rdata;
                    default: ;
                endcase
                if (field == 2'd2) begin
                    field <= '0;
                    idx   <= idx + 1'b1;
                end else begin
                    field <= field + 1'b1;
                end
            end
        end
    end

    assign push_rec = '{idx: idx[IW-1:0], addr: addr_q, data: data_q, we: trace_if.rdata[0]};

    mem_trace_fifo #(
        .WIDTH ($bits(rec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push),
        .push_dat (push_rec),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_vld (rec_valid_o),
        .head_rdy (rec_ready_i),
        .head_dat (head_rec)
    );

    assign rec_idx_o  = head_rec.idx;
    assign rec_addr_o = head_rec.addr;
    assign rec_data_o = head_rec.data;
    assign rec_we_o   = head_rec.we;

    assign busy_o = (state != S_IDLE) && (state != S_DONE);
    assign done_o = (state == S_DONE);

    assign trace_if.req   = req;
    assign trace_if.we    = 1'b0;
    assign trace_if.be    = 4'hF;
    assign trace_if.wdata = 32'h0;
    assign trace_if.addr  = BASE_ADDR + (32'(idx) << 4) + (32'(field) << 2);
endmodule

// File: tb/tb_mem_trace_reader.sv
// Bench for mem_trace_reader: a trace-buffer slave model plus record/bus scoreboards.
module tb_mem_trace_reader;
    localparam int          CAP   = 256;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  num = '0;
    logic        busy, done;
    logic        rec_valid;
    logic        rec_ready = 1'b1;
    logic [7:0]  rec_idx;
    logic [31:0] rec_addr, rec_data;
    logic        rec_we;

    MemSplit32 bus();

    mem_trace_reader #(.CAPACITY(CAP), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .num_entries_i (num),
        .busy_o        (busy),
        .done_o        (done),
        .trace_if      (bus),
        .rec_valid_o   (rec_valid),
        .rec_ready_i   (rec_ready),
        .rec_idx_o     (rec_idx),
        .rec_addr_o    (rec_addr),
        .rec_data_o    (rec_data),
        .rec_we_o      (rec_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  idx;
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
    } exp_rec_t;

    typedef struct {
        int num;
        int exp;
        int hold;
    } vec_t;

    logic [31:0] mem [0:1023];
    exp_rec_t    rec_q[$];
    logic [31:0] addr_q[$];
    exp_rec_t    e_cur;
    int          tests = 0;
    int          fails = 0;
    int          bus_reads = 0;
    int          done_cnt = 0;
    int          stall_rem = 0;
    bit          pend = 0;
    bit          mute = 0;
    bit          inject = 0;
    bit          held = 0;
    logic [72:0] held_v;
    logic [31:0] pend_addr;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name, input logic [79:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got %0h expected none", name, act);
    endtask

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++) begin
            rec_q.push_back('{idx: 8'(i), a: mem[4*i], d: mem[4*i+1], w: mem[4*i+2][0]});
            for (int f = 0; f < 3; f++) begin
                addr_q.push_back(BASE + 32'(16*i) + 32'(4*f));
            end
        end
    endtask

    task automatic pulse_start(input int n);
        @(negedge clk);
        start = 1'b1;
        num   = 9'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!done) note_fail("done_timeout", 80'(n));
    endtask

    // Trace-buffer slave: drives ack/resp at negedge, observes acceptance 3 ns later.
    always @(negedge clk) begin
        bus.resp  = 1'b0;
        bus.rdata = '0;
        if (pend && !(mute && pend_addr == BASE + 32'h10)) begin
            bus.resp  = 1'b1;
            bus.rdata = mem[pend_addr[11:2]];
        end
        pend = 0;
        if (inject) begin
            bus.resp  = 1'b1;
            bus.rdata = 32'hDEAD_BEEF;
            inject    = 0;
        end
        if (stall_rem > 0 && (stall_rem < 5 || (bus.req && bus.addr == BASE + 32'h4))) begin
            bus.ack = 1'b0;
            if (stall_rem < 5) begin
                chk("stall_req", 80'(bus.req), 80'(1));
                chk("stall_addr", 80'(bus.addr), 80'(BASE + 32'h4));
            end
            stall_rem--;
        end else begin
            bus.ack = 1'b1;
        end
        #3;
        if (!rst && bus.req && bus.ack) begin
            pend      = 1;
            pend_addr = bus.addr;
            bus_reads++;
            chk("bus_ctrl", 80'({bus.we, bus.be, bus.wdata}), 80'({1'b0, 4'hF, 32'h0}));
            if (addr_q.size() == 0) note_fail("unexpected_read", 80'(bus.addr));
            else chk("bus_addr", 80'(bus.addr), 80'(addr_q.pop_front()));
        end
    end

    // Record sink scoreboard and hold-stability check.
    always @(negedge clk) begin
        #3;
        if (rst) begin
            held = 0;
        end else begin
            if (rec_valid && held)
                chk("rec_hold", 80'({rec_idx, rec_addr, rec_data, rec_we}), 80'(held_v));
            if (rec_valid && rec_ready) begin
                held = 0;
                if (rec_q.size() == 0) begin
                    note_fail("unexpected_rec", 80'(rec_idx));
                end else begin
                    e_cur = rec_q.pop_front();
                    chk("rec", 80'({rec_idx, rec_addr, rec_data, rec_we}),
                        80'({e_cur.idx, e_cur.a, e_cur.d, e_cur.w}));
                end
            end else if (rec_valid) begin
                held   = 1;
                held_v = {rec_idx, rec_addr, rec_data, rec_we};
            end else begin
                held = 0;
            end
            if (done) done_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[3];
        int   r0;
        int   d0;
        int   n;

        mem[0] = 32'h100; mem[1] = 32'hAA; mem[2]  = 32'h1;
        mem[4] = 32'h104; mem[5] = 32'hBB; mem[6]  = 32'h0;
        mem[8] = 32'h108; mem[9] = 32'hCC; mem[10] = 32'h1;
        for (int i = 3; i < CAP; i++) begin
            mem[4*i]   = 32'h100 + 32'(4*i);
            mem[4*i+1] = 32'hC0DE_0000 + 32'(7*i);
            mem[4*i+2] = 32'h5A5A_0000 | 32'(i % 3 == 0);
            mem[4*i+3] = 32'h0;
        end
        mem[3] = 0; mem[7] = 0; mem[11] = 0;

        vecs[0] = '{num: 3,   exp: 3,   hold: 0};
        vecs[1] = '{num: 6,   exp: 6,   hold: 40};
        vecs[2] = '{num: 300, exp: 256, hold: 0};

        repeat (3) @(negedge clk);
        chk("reset_outs", 80'({busy, done, rec_valid, bus.req, rec_idx, rec_addr, rec_data, rec_we}), 80'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 3; v++) begin
            r0 = bus_reads;
            d0 = done_cnt;
            push_exp(vecs[v].exp);
            rec_ready = (vecs[v].hold == 0);
            pulse_start(vecs[v].num);
            chk("busy_on", 80'(busy), 80'(1));
            @(negedge clk);
            chk("first_req", 80'(bus.req), 80'(1));
            if (vecs[v].hold > 0) begin
                repeat (vecs[v].hold) @(negedge clk);
                chk("stall_reads", 80'(bus_reads - r0), 80'(12));
                chk("stall_req_low", 80'(bus.req), 80'(0));
                rec_ready = 1'b1;
            end
            wait_done(5000);
            @(negedge clk);
            chk("busy_after", 80'(busy), 80'(0));
            chk("recs_left", 80'(rec_q.size()), 80'(0));
            chk("reads", 80'(bus_reads - r0), 80'(3 * vecs[v].exp));
            chk("dones", 80'(done_cnt - d0), 80'(1));
        end

        // Zero entries: no bus access, done three cycles after start.
        r0 = bus_reads;
        pulse_start(0);
        chk("zero_done_c1", 80'(done), 80'(0));
        @(negedge clk);
        chk("zero_done_c2", 80'(done), 80'(0));
        @(negedge clk);
        chk("zero_done_c3", 80'(done), 80'(1));
        @(negedge clk);
        chk("zero_busy", 80'(busy), 80'(0));
        chk("zero_reads", 80'(bus_reads - r0), 80'(0));

        // ack withheld on the second read of entry 0.
        push_exp(1);
        stall_rem = 5;
        pulse_start(1);
        wait_done(200);
        @(negedge clk);
        chk("ack_stall_used", 80'(stall_rem), 80'(0));
        chk("ack_stall_recs", 80'(rec_q.size()), 80'(0));

        // Second start while busy is ignored.
        r0 = bus_reads;
        d0 = done_cnt;
        push_exp(3);
        pulse_start(3);
        repeat (5) @(negedge clk);
        pulse_start(5);
        wait_done(500);
        @(negedge clk);
        chk("mid_start_reads", 80'(bus_reads - r0), 80'(9));
        chk("mid_start_recs", 80'(rec_q.size()), 80'(0));
        chk("mid_start_dones", 80'(done_cnt - d0), 80'(1));

        // Start in the DONE cycle is ignored.
        r0 = bus_reads;
        push_exp(1);
        pulse_start(1);
        wait_done(200);
        start = 1'b1;
        num   = 9'd2;
        @(negedge clk);
        start = 1'b0;
        chk("done_start_busy", 80'(busy), 80'(0));
        @(negedge clk);
        chk("done_start_busy2", 80'(busy), 80'(0));
        chk("done_start_req", 80'(bus.req), 80'(0));
        chk("done_start_reads", 80'(bus_reads - r0), 80'(3));

        // Reset while waiting on entry 1's first read, then a stale resp.
        r0 = bus_reads;
        push_exp(1);
        addr_q.push_back(BASE + 32'h10);
        mute = 1;
        pulse_start(3);
        n = 0;
        while (bus_reads - r0 < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus_reads - r0 < 4) note_fail("abort_reach_timeout", 80'(bus_reads - r0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outs", 80'({busy, done, rec_valid, bus.req, rec_idx, rec_addr, rec_data, rec_we}), 80'(0));
        d0 = done_cnt;
        inject = 1;
        repeat (10) @(negedge clk);
        chk("abort_no_done", 80'(done_cnt - d0), 80'(0));
        chk("abort_idle", 80'({busy, bus.req, rec_valid}), 80'(0));
        chk("abort_recs", 80'(rec_q.size()), 80'(0));
        chk("abort_addrs", 80'(addr_q.size()), 80'(0));
        mute = 0;

        r0 = bus_reads;
        d0 = done_cnt;
        push_exp(1);
        pulse_start(1);
        wait_done(200);
        @(negedge clk);
        chk("post_abort_recs", 80'(rec_q.size()), 80'(0));
        chk("post_abort_reads", 80'(bus_reads - r0), 80'(3));
        chk("post_abort_dones", 80'(done_cnt - d0), 80'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
